vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Pixel-timing master for the pong display path. It is the producer side of the hcnt/vcnt interface that the display renderer consumes.
- Generates the pixel enable, horizontal and vertical counters, and VGA sync pulses.
- Registers the renderer's combinational draw bit into a blanked video output, with syncs delayed to stay aligned.
- Emits a once-per-frame tick so game logic (ball, paddles, score) updates only during vertical blanking.

Parameters:
- CLK_DIV, 2, system clocks per pixel (>=1); 50 MHz / 2 = 25 MHz pixel rate.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch, in pixels.
- H_SYNC, 96, hsync width, in pixels.
- H_BP, 48, horizontal back porch, in pixels.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch, in lines.
- V_SYNC, 2, vsync width, in lines.
- V_BP, 33, vertical back porch, in lines.
- SYNC_POL, 0, asserted sync level (0 = active-low).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- draw  in  1  pixel-on bit from the renderer, a combinational function of hcnt/vcnt.
- hcnt  out  10  horizontal position, 0..H_TOTAL-1.
- vcnt  out  10  vertical position, 0..V_TOTAL-1.
- pix_en  out  1  one-clk pixel strobe.
- hsync  out  1  horizontal sync, registered.
- vsync  out  1  vertical sync, registered.
- video  out  1  blanked, registered pixel to the DAC/pin.
- frame_tick  out  1  one-clk pulse at start of vertical blank.

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). All comparisons are 10-bit unsigned.
- Reset (async assert, released on a clk edge):
  - div_cnt, hcnt, vcnt = 0.
  - video = 0, frame_tick = 0.
  - hsync = vsync = ~SYNC_POL (deasserted).
  - pix_en = 0 while rst is high.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps; advances every clk.
  - pix_en = (div_cnt == CLK_DIV-1) && !rst.
  - CLK_DIV = 1 gives pix_en high every clk after reset.
- Counters (update only on clk edges where pix_en = 1):
  - hcnt increments; at H_TOTAL-1 it wraps to 0 and vcnt steps.
  - vcnt increments on an hcnt wrap; at V_TOTAL-1 (simultaneous with hcnt wrap) it wraps to 0.
  - hcnt/vcnt are register outputs, stable for a full pixel period.
- Sync decode (raw, from current counters):
  - hs_raw = hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751].
  - vs_raw = vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490,491].
  - visible = hcnt < H_ACTIVE && vcnt < V_ACTIVE.
- Output stage (on pix_en edges):
  - video <= draw && visible.
  - hsync <= hs_raw ? SYNC_POL : ~SYNC_POL.
  - vsync <= vs_raw ? SYNC_POL : ~SYNC_POL.
  - Net effect: video, hsync and vsync all lag the counters by exactly one pixel, so they remain mutually aligned.
  - Outputs hold between pix_en edges.
- frame_tick:
  - Registered; asserted for exactly one clk on the edge where the counters become (hcnt=0, vcnt=V_ACTIVE).
  - Low on all other edges, so one pulse per frame.
  - Consumers may update ball/ppos/score in that cycle; the values are stable for all of vblank.
- Reset mid-frame: all state returns to reset values immediately (async); counting resumes from (0,0) with a fresh divider phase. No partial frame_tick is emitted.
- The draw input is sampled only when pix_en = 1, and is ignored whenever visible = 0.

Test Plan:
- Reset: hold rst 5 clks -> hcnt=vcnt=0, video=0, hsync=vsync=1, frame_tick=0, pix_en=0. After release, first pix_en on the 2nd clk edge (CLK_DIV=2).
- Cadence: run 40 clks -> pix_en high every 2nd clk; hcnt reaches 20; counters never change on non-pix_en clks.
- Horizontal wrap/sync: observe one line -> hsync low for exactly 96 pixel periods, from the pixel after hcnt=656 through the pixel after hcnt=751. hcnt 799 -> 0 with vcnt 0 -> 1.
- Vertical wrap/sync/tick:
  - Run a full frame -> vsync low for exactly 2×800 pixels (lines 490–491, one pixel late).
  - vcnt 524 -> 0.
  - frame_tick pulses once, at (0,480); the next pulse comes exactly 420000 pixels (840000 clks) later.
- Video gating: tie draw=1 -> video high for exactly 640 consecutive pixels on each of 480 lines and 0 elsewhere. Tie draw=0 -> video always 0.
- Reset mid-frame: assert rst at (hcnt=300, vcnt=200) with draw=1 -> video=0 and syncs deassert asynchronously (same clk, no edge needed). After release, counting restarts at (0,0); frame_tick stays 0 until (0,480) is reached.

Source files
------------

// File: rtl/vga_if.sv
// vga_if: pixel-timing bus between the timing generator and the renderer.
//
// Timing contract: this bus has no valid/ready pair. The producer owns all
// timing. hcnt/vcnt are registered and hold for a whole pixel period. pix_en
// is a one-clk strobe that marks the clk edge where everything advances. The
// consumer must present draw as a combinational function of the current
// hcnt/vcnt. The producer samples draw only on pix_en edges.
//
// Signals:
//   hcnt, vcnt  - current pixel position (producer -> consumer)
//   pix_en      - one-clk pixel strobe (producer -> consumer)
//   hsync/vsync - registered sync pulses, one pixel behind the counters
//   video       - blanked, registered pixel, aligned with the syncs
//   frame_tick  - one-clk pulse when the counters enter vertical blank
//   draw        - pixel-on bit from the renderer (consumer -> producer)
interface vga_if;
  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic       pix_en;
  logic       hsync;
  logic       vsync;
  logic       video;
  logic       frame_tick;
  logic       draw;

  modport master (
    output hcnt, vcnt, pix_en, hsync, vsync, video, frame_tick,
    input  draw
  );

  modport slave (
    input  hcnt, vcnt, pix_en, hsync, vsync, video, frame_tick,
    output draw
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-timing master for the pong display path.
//
// This block divides the system clock down to a pixel strobe. It runs the
// horizontal and vertical position counters and decodes the sync windows. It
// also registers the renderer's draw bit into a blanked video output, and it
// emits a once-per-frame tick at the start of vertical blank.
//
// Ports:
//   clk  - system clock
//   rst  - asynchronous, active-high reset
//   vif  - vga_if.master: hcnt, vcnt, pix_en, hsync, vsync, video,
//          frame_tick out; draw in
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input logic   clk,
  input logic   rst,
  vga_if.master vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_PRE_BLK = 10'(V_ACTIVE - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       hcnt_q;
  logic [9:0]       vcnt_q;
  logic             pix_en;
  logic             line_end;
  logic             frame_end;
  logic             hs_raw;
  logic             vs_raw;
  logic             visible;
  logic             video_q;
  logic             hsync_q;
  logic             vsync_q;
  logic             tick_q;

  // The strobe is gated by rst so that it reads low during reset, even
  // though div_cnt is already held at its reset value.
  assign pix_en    = (div_cnt == DIV_LAST) && !rst;
  assign line_end  = (hcnt_q == H_LAST);
  assign frame_end = line_end && (vcnt_q == V_LAST);

  assign hs_raw  = (hcnt_q >= HS_START) && (hcnt_q <= HS_END);
  assign vs_raw  = (vcnt_q >= VS_START) && (vcnt_q <= VS_END);
  assign visible = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);

  // Clock divider: free-running, restarts its phase on every reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Position counters: raster order, advancing once per pixel strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else if (pix_en) begin
      if (line_end) begin
        hcnt_q <= '0;
        vcnt_q <= frame_end ? 10'd0 : vcnt_q + 10'd1;
      end else begin
        hcnt_q <= hcnt_q + 10'd1;
      end
    end
  end

  // Output stage: samples the decode of the current counters. The pixel,
  // hsync and vsync therefore all trail the counters by one pixel and stay
  // aligned with each other.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      video_q <= 1'b0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
    end else if (pix_en) begin
      video_q <= vif.draw && visible;
      hsync_q <= hs_raw ? SYNC_POL : ~SYNC_POL;
      vsync_q <= vs_raw ? SYNC_POL : ~SYNC_POL;
    end
  end

  // The tick fires on the edge that moves the counters from the last pixel
  // of the last visible line to (0, V_ACTIVE). It is therefore high in
  // exactly the clk where vertical blank begins, and low on every other edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= pix_en && line_end && (vcnt_q == V_PRE_BLK);
    end
  end

  assign vif.hcnt       = hcnt_q;
  assign vif.vcnt       = vcnt_q;
  assign vif.pix_en     = pix_en;
  assign vif.hsync      = hsync_q;
  assign vif.vsync      = vsync_q;
  assign vif.video      = video_q;
  assign vif.frame_tick = tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen.
//
// dut_a uses the full 640x480 timing. It covers reset, cadence, one full
// line with the horizontal wrap and the hsync window, and a mid-line reset.
// dut_b uses a miniature 16x11 raster with the same structure. It covers
// whole frames: vertical wrap, vsync, frame_tick placement and period, video
// gating, and a reset during the sync window.
// Sampling is done on the falling clk edge.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  vga_if if_a ();
  vga_if if_b ();

  vga_timing_gen dut_a (
    .clk (clk),
    .rst (rst_a),
    .vif (if_a)
  );

  // Miniature raster: H 8+2+3+3 = 16, V 6+1+2+2 = 11, 176 pixels per frame.
  vga_timing_gen #(
    .CLK_DIV (2),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b0)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .vif (if_b)
  );

  int checks = 0;
  int errors = 0;
  int hs_low, hs_first, hs_last, vs_low, vid_hi;
  int tick_cnt, tick_i0, tick_i1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // p is the number of pixel strobes consumed since the reset release. The
  // counters show pixel p. The registered outputs show pixel p-1, or their
  // reset values when p = 0.
  task automatic check_pix(input string tag, input int p, input int ht, input int vt,
                           input int ha, input int v_act, input int hs0, input int hs1,
                           input int vs0, input int vs1, input logic drw,
                           input logic [9:0] hc, input logic [9:0] vc,
                           input logic hs, input logic vs, input logic vid);
    int   qh, qv;
    logic e_hs, e_vs, e_vid;
    chk({tag, " hcnt"}, 32'(hc), 32'(p % ht));
    chk({tag, " vcnt"}, 32'(vc), 32'((p / ht) % vt));
    if (p == 0) begin
      e_hs  = 1'b1;
      e_vs  = 1'b1;
      e_vid = 1'b0;
    end else begin
      qh    = (p - 1) % ht;
      qv    = ((p - 1) / ht) % vt;
      e_hs  = !(qh >= hs0 && qh <= hs1);
      e_vs  = !(qv >= vs0 && qv <= vs1);
      e_vid = drw && (qh < ha) && (qv < v_act);
    end
    chk({tag, " hsync"}, 32'(hs), 32'(e_hs));
    chk({tag, " vsync"}, 32'(vs), 32'(e_vs));
    chk({tag, " video"}, 32'(vid), 32'(e_vid));
  endtask

  task automatic run_a(input int n, input logic drw);
    int p;
    if_a.draw = drw;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      @(negedge clk);
      p = i / 2;
      chk("a pix_en", 32'(if_a.pix_en), 32'(i % 2));
      chk("a frame_tick", 32'(if_a.frame_tick), 32'd0);
      check_pix("a", p, 800, 525, 640, 480, 656, 751, 490, 491, drw,
                if_a.hcnt, if_a.vcnt, if_a.hsync, if_a.vsync, if_a.video);
      if (i == 1598) begin
        chk("a hcnt at line end", 32'(if_a.hcnt), 32'd799);
        chk("a vcnt at line end", 32'(if_a.vcnt), 32'd0);
      end
      if (i == 1600) begin
        chk("a hcnt after wrap", 32'(if_a.hcnt), 32'd0);
        chk("a vcnt after wrap", 32'(if_a.vcnt), 32'd1);
      end
      if (i % 2 == 0 && p >= 1 && p <= 800) begin
        if (if_a.hsync == 1'b0) begin
          hs_low++;
          if (hs_first < 0) hs_first = p;
          hs_last = p;
        end
        if (if_a.video == 1'b1) vid_hi++;
      end
    end
  endtask

  task automatic run_b(input int n, input logic drw);
    int p;
    if_b.draw = drw;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      @(negedge clk);
      p = i / 2;
      chk("b pix_en", 32'(if_b.pix_en), 32'(i % 2));
      chk("b frame_tick", 32'(if_b.frame_tick), 32'(i % 2 == 0 && p % 176 == 96));
      check_pix("b", p, 16, 11, 8, 6, 10, 12, 7, 8, drw,
                if_b.hcnt, if_b.vcnt, if_b.hsync, if_b.vsync, if_b.video);
      if (i == 350) begin
        chk("b hcnt at frame end", 32'(if_b.hcnt), 32'd15);
        chk("b vcnt at frame end", 32'(if_b.vcnt), 32'd10);
      end
      if (i == 352) begin
        chk("b hcnt after frame wrap", 32'(if_b.hcnt), 32'd0);
        chk("b vcnt after frame wrap", 32'(if_b.vcnt), 32'd0);
      end
      if (if_b.frame_tick == 1'b1) begin
        tick_cnt++;
        if (tick_cnt == 1) tick_i0 = i;
        else if (tick_cnt == 2) tick_i1 = i;
      end
      if (i % 2 == 0 && p >= 1 && p <= 176) begin
        if (if_b.vsync == 1'b0) vs_low++;
        if (if_b.video == 1'b1) vid_hi++;
      end
    end
  endtask

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    if_a.draw = 1'b0;
    if_b.draw = 1'b0;
    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);

    // Reset state
    chk("a rst hcnt", 32'(if_a.hcnt), 32'd0);
    chk("a rst vcnt", 32'(if_a.vcnt), 32'd0);
    chk("a rst video", 32'(if_a.video), 32'd0);
    chk("a rst hsync", 32'(if_a.hsync), 32'd1);
    chk("a rst vsync", 32'(if_a.vsync), 32'd1);
    chk("a rst frame_tick", 32'(if_a.frame_tick), 32'd0);
    chk("a rst pix_en", 32'(if_a.pix_en), 32'd0);
    chk("b rst pix_en", 32'(if_b.pix_en), 32'd0);
    chk("b rst hsync", 32'(if_b.hsync), 32'd1);

    // dut_a: cadence, one full line plus part of the next, with draw = 1
    hs_low = 0; hs_first = -1; hs_last = -1; vid_hi = 0;
    rst_a = 1'b0;
    run_a(2200, 1'b1);
    chk("a hsync low pixels", hs_low, 96);
    chk("a hsync first low pixel", hs_first, 657);
    chk("a hsync last low pixel", hs_last, 752);
    chk("a video high pixels line0", vid_hi, 640);
    chk("a hcnt before reset", 32'(if_a.hcnt), 32'd300);
    chk("a vcnt before reset", 32'(if_a.vcnt), 32'd1);
    chk("a video before reset", 32'(if_a.video), 32'd1);

    // dut_a: asynchronous reset mid-line, checked before any clk edge
    rst_a = 1'b1;
    #1;
    chk("a async video", 32'(if_a.video), 32'd0);
    chk("a async hcnt", 32'(if_a.hcnt), 32'd0);
    chk("a async vcnt", 32'(if_a.vcnt), 32'd0);
    chk("a async pix_en", 32'(if_a.pix_en), 32'd0);
    chk("a async hsync", 32'(if_a.hsync), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    run_a(40, 1'b1);
    chk("a hcnt after 40 clks", 32'(if_a.hcnt), 32'd20);

    // dut_b: frames with draw = 1, then a reset inside the h/v sync window
    vs_low = 0; vid_hi = 0; tick_cnt = 0; tick_i0 = -1; tick_i1 = -1;
    rst_b = 1'b0;
    run_b(600, 1'b1);
    chk("b frame_tick count", tick_cnt, 2);
    chk("b first frame_tick clk", tick_i0, 192);
    chk("b frame_tick period clks", tick_i1 - tick_i0, 352);
    chk("b vsync low pixels", vs_low, 32);
    chk("b video high pixels", vid_hi, 48);
    chk("b hsync before reset", 32'(if_b.hsync), 32'd0);
    chk("b vsync before reset", 32'(if_b.vsync), 32'd0);
    rst_b = 1'b1;
    #1;
    chk("b async hsync", 32'(if_b.hsync), 32'd1);
    chk("b async vsync", 32'(if_b.vsync), 32'd1);
    chk("b async video", 32'(if_b.video), 32'd0);
    chk("b async hcnt", 32'(if_b.hcnt), 32'd0);
    chk("b async vcnt", 32'(if_b.vcnt), 32'd0);
    chk("b async frame_tick", 32'(if_b.frame_tick), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);

    // dut_b: restart with draw = 0; the first tick must wait for (0,6)
    vs_low = 0; vid_hi = 0; tick_cnt = 0; tick_i0 = -1; tick_i1 = -1;
    rst_b = 1'b0;
    run_b(400, 1'b0);
    chk("b restart frame_tick count", tick_cnt, 1);
    chk("b restart first tick clk", tick_i0, 192);
    chk("b draw0 video high pixels", vid_hi, 0);
    chk("b restart vsync low pixels", vs_low, 32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
